// File: rtl/vga_comp_pkg.sv
// Shared types for the VGA sprite compositor: sprite slot record, texture
// class names, screen width and the RGB -> BGR pin-order helper.
package vga_comp_pkg;

  localparam int SCREEN_W = 640;

  typedef enum logic [1:0] {
    CLS_BLACK,
    CLS_SKELETON,
    CLS_CREEPER,
    CLS_ZOMBIE
  } sprite_cls_e;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [9:0]  w;
    logic [8:0]  h;
    sprite_cls_e cls;
    logic        vis;
    logic        blink;
  } sprite_t;

  localparam sprite_t SPRITE_EMPTY = sprite_t'('0);

  // ROM data is {r,g,b}; the DAC pins expect {b,g,r}.
  function automatic logic [11:0] rgb_to_bgr(input logic [11:0] rgb);
    return {rgb[3:0], rgb[7:4], rgb[11:8]};
  endfunction

endpackage

// File: rtl/vga_comp_hit_sel.sv
// Combinational hit test over the active sprite table plus lowest-index
// priority select. Besides the hit flag it hands back the winning slot's
// texture class and the pixel offset inside that sprite.
module vga_comp_hit_sel
  import vga_comp_pkg::*;
#(
  parameter int NUM_SPRITES = 16
) (
  input  sprite_t     i_table [NUM_SPRITES],
  input  logic [9:0]  i_pix_x,
  input  logic [8:0]  i_pix_y,
  input  logic        i_blink_phase,
  output logic        o_hit,
  output sprite_cls_e o_cls,
  output logic [9:0]  o_dx,
  output logic [8:0]  o_dy
);

  logic [NUM_SPRITES-1:0] w_slot_hit;

  // Per-slot rectangle test; ends are one bit wider so sprites running past
  // the right/bottom edge of the coordinate space do not wrap around.
  always_comb begin
    w_slot_hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_slot_hit[i] = i_table[i].vis
                   && !(i_table[i].blink && i_blink_phase)
                   && ({1'b0, i_pix_x} >= {1'b0, i_table[i].x})
                   && ({1'b0, i_pix_x} <  ({1'b0, i_table[i].x} + {1'b0, i_table[i].w}))
                   && ({1'b0, i_pix_y} >= {1'b0, i_table[i].y})
                   && ({1'b0, i_pix_y} <  ({1'b0, i_table[i].y} + {1'b0, i_table[i].h}));
    end
  end

  // Scan from the highest index down so the lowest hitting slot writes last.
  always_comb begin
    o_hit = 1'b0;
    o_cls = CLS_BLACK;
    o_dx  = '0;
    o_dy  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_slot_hit[i]) begin
        o_hit = 1'b1;
        o_cls = i_table[i].cls;
        o_dx  = i_pix_x - i_table[i].x;
        o_dy  = i_pix_y - i_table[i].y;
      end
    end
  end

endmodule

// File: rtl/vga_sprite_compositor.sv
// Pipelined sprite compositor for the VGA path. Game logic writes a shadow
// sprite table that is copied to the active table on frame_start; each pixel
// is hit-tested (S0), waits ROM_LAT cycles for sprite/background ROM data,
// and is resolved to a registered BGR colour.
// Optional feature macro: VGA_COMP_BLINK_EN (frame counter + blink phase that
// hides slots with the blink attribute on alternate BLINK_FRAMES periods).
module vga_sprite_compositor
  import vga_comp_pkg::*;
#(
`ifdef VGA_COMP_BLINK_EN
  parameter int          BLINK_FRAMES = 16,
`endif
  parameter int          NUM_SPRITES  = 16,
  parameter int          NUM_CLASSES  = 4,
  parameter int          TILE_SIZE    = 30,
  parameter int          ROM_LAT      = 1,
  parameter logic [11:0] KEY_COLOR    = 12'hF0F,
  parameter int          UPPER_BOUND  = 20,
  parameter int          LOWER_BOUND  = 460,
  parameter logic [11:0] BORDER_COLOR = 12'h000,
  localparam int         IDX_W        = $clog2(NUM_SPRITES),
  localparam int         CLS_IW       = $clog2(NUM_CLASSES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_valid,
  input  logic [9:0]        i_pix_x,
  input  logic [8:0]        i_pix_y,
  input  logic              i_frame_start,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [9:0]        i_wr_x,
  input  logic [8:0]        i_wr_y,
  input  logic [9:0]        i_wr_w,
  input  logic [8:0]        i_wr_h,
  input  logic [CLS_IW-1:0] i_wr_class,
  input  logic              i_wr_vis,
  input  logic              i_wr_blink,
  output logic [9:0]        o_rom_addr,
  output logic [CLS_IW-1:0] o_rom_class,
  input  logic [11:0]       i_rom_data,
  output logic [18:0]       o_bg_addr,
  input  logic [11:0]       i_bg_data,
  output logic [11:0]       o_rgb,
  output logic              o_rgb_valid
);

  sprite_t r_shadow [NUM_SPRITES];
  sprite_t r_active [NUM_SPRITES];

  sprite_t w_wr_slot;
  logic    w_wr_fire;
  logic    w_blink_phase;

  // The commit cycle owns the shadow table, so writes are refused there.
  assign o_wr_ready = !i_rst && !i_frame_start;
  assign w_wr_fire  = i_wr_valid && o_wr_ready && (32'(i_wr_idx) < NUM_SPRITES);
  assign w_wr_slot  = '{x: i_wr_x, y: i_wr_y, w: i_wr_w, h: i_wr_h,
                        cls: sprite_cls_e'(2'(i_wr_class)),
                        vis: i_wr_vis, blink: i_wr_blink};

  // Shadow table takes writes; active table changes only at frame_start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shadow[i] <= SPRITE_EMPTY;
        r_active[i] <= SPRITE_EMPTY;
      end
    end else begin
      if (w_wr_fire)     r_shadow[i_wr_idx] <= w_wr_slot;
      if (i_frame_start) r_active <= r_shadow;
    end
  end

`ifdef VGA_COMP_BLINK_EN
  localparam int BCW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  logic [BCW-1:0] r_blink_cnt;
  logic           r_blink_phase;

  // Count frames; every BLINK_FRAMES frame starts flip the blink phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (i_frame_start) begin
      if (r_blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= !r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_blink_phase = r_blink_phase;
`else
  assign w_blink_phase = 1'b0;
`endif

  logic        w_hit;
  sprite_cls_e w_hit_cls;
  logic [9:0]  w_dx;
  logic [8:0]  w_dy;

  vga_comp_hit_sel #(.NUM_SPRITES(NUM_SPRITES)) u_hit_sel (
    .i_table       (r_active),
    .i_pix_x       (i_pix_x),
    .i_pix_y       (i_pix_y),
    .i_blink_phase (w_blink_phase),
    .o_hit         (w_hit),
    .o_cls         (w_hit_cls),
    .o_dx          (w_dx),
    .o_dy          (w_dy)
  );

  logic [4:0]  w_tx;
  logic [4:0]  w_ty;
  logic [9:0]  w_rom_addr;
  logic        w_border;
  logic [18:0] w_bg_addr;

  assign w_tx       = 5'(w_dx % 10'(TILE_SIZE));
  assign w_ty       = 5'(w_dy % 9'(TILE_SIZE));
  assign w_rom_addr = w_hit ? (10'(w_ty) * 10'(TILE_SIZE) + 10'(w_tx)) : 10'd0;
  assign w_border   = ({1'b0, i_pix_y} < 10'(UPPER_BOUND)) ||
                      ({1'b0, i_pix_y} >= 10'(LOWER_BOUND));
  assign w_bg_addr  = w_border ? 19'd0
                    : 19'(i_pix_x) + 19'(i_pix_y - 9'(UPPER_BOUND)) * 19'(SCREEN_W);

  logic r_s0_hit;
  logic r_s0_border;
  logic r_s0_valid;

  // S0: register ROM addresses and the per-pixel flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rom_addr  <= '0;
      o_rom_class <= '0;
      o_bg_addr   <= '0;
      r_s0_hit    <= 1'b0;
      r_s0_border <= 1'b0;
      r_s0_valid  <= 1'b0;
    end else begin
      o_rom_addr  <= w_rom_addr;
      o_rom_class <= w_hit ? CLS_IW'(w_hit_cls) : '0;
      o_bg_addr   <= w_bg_addr;
      r_s0_hit    <= w_hit;
      r_s0_border <= w_border;
      r_s0_valid  <= i_pix_valid;
    end
  end

  logic [ROM_LAT-1:0] r_dly_hit;
  logic [ROM_LAT-1:0] r_dly_border;
  logic [ROM_LAT-1:0] r_dly_valid;

  // Delay the flags so they line up with the ROM read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dly_hit    <= '0;
      r_dly_border <= '0;
      r_dly_valid  <= '0;
    end else begin
      r_dly_hit[0]    <= r_s0_hit;
      r_dly_border[0] <= r_s0_border;
      r_dly_valid[0]  <= r_s0_valid;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_dly_hit[i]    <= r_dly_hit[i-1];
        r_dly_border[i] <= r_dly_border[i-1];
        r_dly_valid[i]  <= r_dly_valid[i-1];
      end
    end
  end

  logic [11:0] w_final;

  // Colour select: border beats sprite, key-coloured texels show background.
  always_comb begin
    w_final = i_bg_data;
    if (r_dly_border[ROM_LAT-1]) begin
      w_final = BORDER_COLOR;
    end else if (r_dly_hit[ROM_LAT-1] && (i_rom_data != KEY_COLOR)) begin
      w_final = i_rom_data;
    end
  end

  // Output register; blanking pixels drive black.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rgb       <= '0;
      o_rgb_valid <= 1'b0;
    end else if (r_dly_valid[ROM_LAT-1]) begin
      o_rgb       <= rgb_to_bgr(w_final);
      o_rgb_valid <= 1'b1;
    end else begin
      o_rgb       <= '0;
      o_rgb_valid <= 1'b0;
    end
  end

endmodule
